// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART frame serializer with one-entry holding register
// Frames start / data (LSB first) / optional parity / stop onto a registered idle-high line.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_full;
  logic [DATA_BITS-1:0] shift;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 par_en_q;
  logic                 par_bit;
  logic                 bit_end;
  logic                 load;

  assign bit_end  = (clk_cnt == CLK_LAST);
  assign load     = hold_full && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
  assign tx_ready = ~hold_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      hold_data  <= '0;
      hold_full  <= 1'b0;
      shift      <= '0;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      par_en_q   <= 1'b0;
      par_bit    <= 1'b0;
      serial_out <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      // Line outputs are registered from the current state, so they trail it by one cycle
      case (state)
        S_START:  serial_out <= 1'b0;
        S_DATA:   serial_out <= shift[0];
        S_PARITY: serial_out <= par_bit;
        default:  serial_out <= 1'b1;
      endcase
      tx_busy <= (state != S_IDLE);
      tx_done <= (state == S_STOP) && bit_end;

      if (tx_valid && !hold_full) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end

      if (load) begin
        hold_full <= 1'b0;
        shift     <= hold_data;
        par_en_q  <= parity_en;
        par_bit   <= parity_odd ? ~^hold_data : ^hold_data;
      end

      if (state == S_IDLE || bit_end) clk_cnt <= '0;
      else                            clk_cnt <= clk_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (hold_full) state <= S_START;
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shift <= shift >> 1;
            if (bit_cnt == BIT_LAST) state <= par_en_q ? S_PARITY : S_STOP;
            else                     bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_end) state <= S_STOP;
        end
        S_STOP: begin
          if (bit_end) state <= hold_full ? S_START : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
